// File: rtl/pdm_stream_source.sv
// PDM microphone front end: divided PDM clock, 2-flop capture, packet framing,
// show-ahead FIFO onto a valid/ready source port, plus a small CSR window.
module pdm_stream_source #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [15:0] DEF_DIV     = 16'd15,
    parameter logic [15:0] DEF_PKT_LEN = 16'd64,
    parameter logic [31:0] BLOCK_ID    = 32'h50444D31
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    output logic        oPDM_CLK,
    input  logic        iPDM_DATA,
    output logic        s_clock,
    output logic        s_data_valid,
    input  logic        s_ready,
    output logic        s_start_packet,
    output logic        s_end_packet,
    output logic        s_data,
    input  logic [2:0]  iCSR_ADDRESS,
    input  logic        iCSR_READ,
    output logic [31:0] oCSR_READ_DATA,
    input  logic        iCSR_WRITE,
    input  logic [31:0] iCSR_WRITE_DATA
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t state, next_state;

    logic        en, ovf_sticky, pdm_clk, sync1, sync2, running;
    logic [15:0] div_reg, pkt_len_reg, div_cur, div_cnt, ovf_count, len_q, bit_cnt;
    logic [15:0] eff_len, cur_len;
    logic [2:0]  mem [FIFO_DEPTH];
    logic [2:0]  head;
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic [7:0]  level_byte;
    logic [31:0] read_mux;
    logic        wrap, fall, can_sample, push, push_ok, overflow, empty, full, xfer;
    logic        is_sop, is_eop, clr_ovf, unused_bits;

    assign s_clock     = iCLOCK;
    assign oPDM_CLK    = pdm_clk;
    assign unused_bits = ^iCSR_WRITE_DATA[31:16];

    assign clr_ovf    = iCSR_WRITE && (iCSR_ADDRESS == 3'd0) && iCSR_WRITE_DATA[1];
    assign wrap       = (div_cnt == div_cur);
    assign fall       = (state != IDLE) && wrap && pdm_clk;
    // Once stopping, only bits that complete the open packet are taken.
    assign can_sample = (state == RUN) || ((state == STOP) && (bit_cnt != 16'd0));
    assign push       = fall && can_sample;
    assign level      = wr_ptr - rd_ptr;
    assign level_byte = 8'(level);
    assign empty      = (level == '0);
    assign full       = (level == LEVEL_FULL);
    assign xfer       = !empty && s_ready;
    assign push_ok    = push && (!full || xfer);
    assign overflow   = push && !push_ok;
    assign eff_len    = (pkt_len_reg == 16'd0) ? 16'd1 : pkt_len_reg;
    assign cur_len    = (bit_cnt == 16'd0) ? eff_len : len_q;
    assign is_sop     = (bit_cnt == 16'd0);
    assign is_eop     = (bit_cnt == cur_len - 16'd1);

    always_ff @(posedge iCLOCK) begin
        if (iRESET) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (en) next_state = RUN;
            RUN:  if (!en) next_state = STOP;
            STOP: begin
                if (en)
                    next_state = RUN;
                else if ((bit_cnt == 16'd0) || (push_ok && is_eop))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        running = (state != IDLE);
    end

    // Cleared on entry to and exit from IDLE so the PDM clock always restarts low.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            div_cnt <= 16'd0;
            div_cur <= DEF_DIV;
            pdm_clk <= 1'b0;
        end else if ((state == IDLE) || (next_state == IDLE)) begin
            div_cnt <= 16'd0;
            div_cur <= div_reg;
            pdm_clk <= 1'b0;
        end else if (wrap) begin
            div_cnt <= 16'd0;
            div_cur <= div_reg;
            pdm_clk <= ~pdm_clk;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            bit_cnt <= 16'd0;
            len_q   <= 16'd1;
        end else begin
            sync1 <= iPDM_DATA;
            sync2 <= sync1;
            if (push_ok) begin
                if (is_sop) len_q <= eff_len;
                bit_cnt <= is_eop ? 16'd0 : bit_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {is_sop, is_eop, sync2};
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (xfer)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head           = mem[rd_ptr[AW-1:0]];
    assign s_data_valid   = !empty;
    assign s_start_packet = !empty && head[2];
    assign s_end_packet   = !empty && head[1];
    assign s_data         = !empty && head[0];

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            en          <= 1'b0;
            div_reg     <= DEF_DIV;
            pkt_len_reg <= DEF_PKT_LEN;
        end else if (iCSR_WRITE) begin
            case (iCSR_ADDRESS)
                3'd0:    en          <= iCSR_WRITE_DATA[0];
                3'd1:    div_reg     <= iCSR_WRITE_DATA[15:0];
                3'd2:    pkt_len_reg <= iCSR_WRITE_DATA[15:0];
                default: ;
            endcase
        end
    end

    // A clear that coincides with a dropped sample still records that sample.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            ovf_count  <= 16'd0;
            ovf_sticky <= 1'b0;
        end else if (clr_ovf) begin
            ovf_count  <= overflow ? 16'd1 : 16'd0;
            ovf_sticky <= overflow;
        end else if (overflow) begin
            if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
            ovf_sticky <= 1'b1;
        end
    end

    always_comb begin
        read_mux = 32'd0;
        case (iCSR_ADDRESS)
            3'd0:    read_mux = {31'd0, en};
            3'd1:    read_mux = {16'd0, div_reg};
            3'd2:    read_mux = {16'd0, pkt_len_reg};
            3'd3:    read_mux = {ovf_count, level_byte, 6'd0, running, ovf_sticky};
            3'd4:    read_mux = BLOCK_ID;
            default: read_mux = 32'd0;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET)         oCSR_READ_DATA <= 32'd0;
        else if (iCSR_READ) oCSR_READ_DATA <= read_mux;
    end
endmodule

// File: tb/tb_pdm_stream_source.sv
// Directed bench for pdm_stream_source: framing, backpressure, stop behaviour,
// packet length changes, full-FIFO pass-through and the CSR window.
module tb_pdm_stream_source;
    logic        clk, rst, pdm_clk, pdm_data, s_clock, s_data_valid, s_ready;
    logic        s_start_packet, s_end_packet, s_data;
    logic [2:0]  csr_address;
    logic        csr_read_en, csr_write_en;
    logic [31:0] csr_read_data, csr_write_data;

    int          passed, total, base, cyc, k, rise1, rise2;
    logic        prev, found, pdm_or;
    logic [31:0] rd;
    logic [15:0] sv, ev, dv;
    logic [7:0]  pat;
    bit   [2:0]  rec_q[$];

    pdm_stream_source dut (
        .iCLOCK(clk), .iRESET(rst), .oPDM_CLK(pdm_clk), .iPDM_DATA(pdm_data),
        .s_clock(s_clock), .s_data_valid(s_data_valid), .s_ready(s_ready),
        .s_start_packet(s_start_packet), .s_end_packet(s_end_packet), .s_data(s_data),
        .iCSR_ADDRESS(csr_address), .iCSR_READ(csr_read_en), .oCSR_READ_DATA(csr_read_data),
        .iCSR_WRITE(csr_write_en), .iCSR_WRITE_DATA(csr_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every accepted beat on the source port, as {sop, eop, data}.
    always @(negedge clk) begin
        if (!rst && s_data_valid && s_ready)
            rec_q.push_back({s_start_packet, s_end_packet, s_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        csr_address = a; csr_write_data = d; csr_write_en = 1'b1;
        tick();
        csr_write_en = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        csr_address = a; csr_read_en = 1'b1;
        tick();
        csr_read_en = 1'b0;
        d = csr_read_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_entries(input int n, input int budget, input string tag);
        int w;
        w = 0;
        while (rec_q.size() < n && w < budget) begin
            tick();
            w++;
        end
        check(tag, 32'(rec_q.size() >= n), 32'd1);
    endtask

    task automatic collect(input int b, input int n, output logic [15:0] so, eo, d);
        bit [2:0] e;
        so = '0; eo = '0; d = '0;
        for (int i = 0; i < n; i++) begin
            if (b + i < rec_q.size()) begin
                e = rec_q[b + i];
                so[i] = e[2]; eo[i] = e[1]; d[i] = e[0];
            end
        end
    endtask

    initial begin
        passed = 0; total = 0;
        pat = 8'b01001101;
        rst = 1'b1; pdm_data = 1'b0; s_ready = 1'b0;
        csr_address = 3'd0; csr_read_en = 1'b0; csr_write_en = 1'b0; csr_write_data = 32'd0;
        tick(); tick(); tick();
        rst = 1'b0;

        check("rst_valid", 32'(s_data_valid), 32'd0);
        check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
        check("rst_sop_eop_data", 32'({s_start_packet, s_end_packet, s_data}), 32'd0);
        check("rst_read_data", csr_read_data, 32'd0);
        check("s_clock_follows", 32'(s_clock), 32'(clk));
        csr_read(3'd1, rd); check("rst_div", rd, 32'd15);
        csr_read(3'd2, rd); check("rst_pkt_len", rd, 32'd64);
        csr_read(3'd3, rd); check("rst_status", rd, 32'd0);
        csr_read(3'd0, rd); check("rst_ctrl", rd, 32'd0);

        // Two 4-bit packets of a known pattern; data changes right after each sample.
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd4);
        s_ready = 1'b1; pdm_data = pat[0];
        base = rec_q.size();
        csr_write(3'd0, 32'd1);
        k = 0; prev = 1'b0; rise1 = -1; rise2 = -1; cyc = 0;
        while (rec_q.size() < base + 8 && cyc < 200) begin
            tick(); cyc++;
            if (pdm_clk && !prev) begin
                if (rise1 < 0) rise1 = cyc;
                else if (rise2 < 0) rise2 = cyc;
            end
            if (!pdm_clk && prev) begin
                k++;
                if (k < 8) pdm_data = pat[k];
            end
            prev = pdm_clk;
        end
        check("t1_count", 32'(rec_q.size() >= base + 8), 32'd1);
        collect(base, 8, sv, ev, dv);
        check("t1_data", 32'(dv), 32'h4D);
        check("t1_sop", 32'(sv), 32'h11);
        check("t1_eop", 32'(ev), 32'h88);
        check("t1_pdm_period", 32'(rise2 - rise1), 32'd4);

        // Backpressure with DIV=0: fill, overflow, clear, then drain.
        do_reset();
        s_ready = 1'b0; pdm_data = 1'b1;
        csr_write(3'd1, 32'd0);
        csr_write(3'd2, 32'd4);
        csr_write(3'd0, 32'd1);
        repeat (70) tick();
        csr_read(3'd3, rd);
        check("t2_level_full", 32'(rd[15:8]), 32'd16);
        check("t2_sticky", 32'(rd[0]), 32'd1);
        check("t2_ovf_counted", 32'(rd[31:16] != 16'd0), 32'd1);
        check("t2_running", 32'(rd[1]), 32'd1);
        csr_write(3'd0, 32'd0);
        repeat (4) tick();
        csr_write(3'd0, 32'd2);
        csr_read(3'd3, rd);
        check("t2_clr_count", 32'(rd[31:16]), 32'd0);
        check("t2_clr_sticky", 32'(rd[0]), 32'd0);
        check("t2_idle", 32'(rd[1]), 32'd0);
        check("t2_level_kept", 32'(rd[15:8]), 32'd16);
        csr_read(3'd0, rd); check("t2_ctrl_read", rd, 32'd0);
        base = rec_q.size();
        s_ready = 1'b1;
        wait_entries(base + 16, 60, "t2_drain");
        repeat (3) tick();
        check("t2_drain_exact", 32'(rec_q.size() - base), 32'd16);
        check("t2_empty_after", 32'(s_data_valid), 32'd0);
        collect(base, 16, sv, ev, dv);
        check("t2_sop", 32'(sv), 32'h1111);
        check("t2_eop", 32'(ev), 32'h8888);
        check("t2_data", 32'(dv), 32'hFFFF);

        // Dropping EN mid-packet must still finish the packet, then go idle.
        do_reset();
        s_ready = 1'b1; pdm_data = 1'b1;
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd8);
        base = rec_q.size();
        csr_write(3'd0, 32'd1);
        wait_entries(base + 4, 100, "t3_first4");
        csr_write(3'd0, 32'd0);
        csr_read(3'd3, rd);
        check("t3_running_in_stop", 32'(rd[1]), 32'd1);
        wait_entries(base + 8, 100, "t3_all8");
        pdm_or = 1'b0;
        repeat (20) begin
            tick();
            pdm_or = pdm_or | pdm_clk;
        end
        csr_read(3'd3, rd);
        check("t3_idle", 32'(rd[1]), 32'd0);
        check("t3_exact8", 32'(rec_q.size() - base), 32'd8);
        collect(base, 8, sv, ev, dv);
        check("t3_eop_last", 32'(ev), 32'h80);
        check("t3_pdm_held_low", 32'(pdm_or), 32'd0);

        // PKT_LEN=0 behaves as single-bit packets.
        do_reset();
        s_ready = 1'b1;
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd0);
        base = rec_q.size();
        csr_write(3'd0, 32'd1);
        wait_entries(base + 4, 100, "t4_len0_count");
        collect(base, 4, sv, ev, dv);
        check("t4_len0_sop", 32'(sv), 32'hF);
        check("t4_len0_eop", 32'(ev), 32'hF);

        // Length change mid-packet: 3, then 5, 5.
        do_reset();
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd3);
        base = rec_q.size();
        csr_write(3'd0, 32'd1);
        wait_entries(base + 1, 100, "t4_first_bit");
        csr_write(3'd2, 32'd5);
        wait_entries(base + 13, 200, "t4_thirteen");
        collect(base, 13, sv, ev, dv);
        check("t4_relen_sop", 32'(sv), 32'h0109);
        check("t4_relen_eop", 32'(ev), 32'h1084);

        // Full FIFO: a transfer in the same cycle as a push lets the push in.
        do_reset();
        s_ready = 1'b0; pdm_data = 1'b1;
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd4);
        csr_write(3'd0, 32'd1);
        repeat (90) tick();
        csr_read(3'd3, rd);
        check("t5_level_full", 32'(rd[15:8]), 32'd16);
        prev = pdm_clk; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pdm_clk && !prev) found = 1'b1;
            prev = pdm_clk;
        end
        check("t5_found_rise", 32'(found), 32'd1);
        csr_address = 3'd0; csr_write_data = 32'd3; csr_write_en = 1'b1;
        tick();
        csr_write_en = 1'b0;
        base = rec_q.size();
        s_ready = 1'b1; csr_address = 3'd3; csr_read_en = 1'b1;
        tick();
        s_ready = 1'b0;
        tick();
        csr_read_en = 1'b0;
        rd = csr_read_data;
        check("t5_no_overflow", 32'(rd[31:16]), 32'd0);
        check("t5_no_sticky", 32'(rd[0]), 32'd0);
        check("t5_level_same", 32'(rd[15:8]), 32'd16);
        check("t5_one_transfer", 32'(rec_q.size() - base), 32'd1);

        // ID, unmapped addresses, and reset while a packet is open.
        csr_read(3'd4, rd); check("t6_id", rd, 32'h50444D31);
        csr_read(3'd5, rd); check("t6_addr5_zero", rd, 32'd0);
        csr_write(3'd5, 32'hFFFF_FFFF);
        csr_read(3'd1, rd); check("t6_write5_ignored", rd, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", 32'(s_data_valid), 32'd0);
        check("t6_rst_pdm_clk", 32'(pdm_clk), 32'd0);
        check("t6_rst_read_data", csr_read_data, 32'd0);
        csr_read(3'd3, rd); check("t6_rst_status", rd, 32'd0);
        csr_read(3'd1, rd); check("t6_rst_div", rd, 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
